// File: rtl/board_state_pkg.sv
// Purpose: shared game constants for the tic-tac-toe turn logic (cell/content/outcome codes, FSM states).
// Latency: n/a (constants and pure combinational helpers only).
// Backpressure: n/a.
package board_state_pkg;

  // Cell codes, row-major; 0 and 10..15 are not cells
  localparam logic [3:0] CELL_A1 = 4'd1;
  localparam logic [3:0] CELL_A2 = 4'd2;
  localparam logic [3:0] CELL_A3 = 4'd3;
  localparam logic [3:0] CELL_B1 = 4'd4;
  localparam logic [3:0] CELL_B2 = 4'd5;
  localparam logic [3:0] CELL_B3 = 4'd6;
  localparam logic [3:0] CELL_C1 = 4'd7;
  localparam logic [3:0] CELL_C2 = 4'd8;
  localparam logic [3:0] CELL_C3 = 4'd9;

  // Cell contents
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Game outcome codes
  localparam logic [1:0] OUTCOME_IN_PROGRESS = 2'b00;
  localparam logic [1:0] OUTCOME_WIN         = 2'b01;
  localparam logic [1:0] OUTCOME_LOSE        = 2'b10;
  localparam logic [1:0] OUTCOME_TIE         = 2'b11;

  // Number of moves that fills the board
  localparam logic [3:0] FULL_COUNT = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_EVAL   = 3'd3,
    ST_REJECT = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  function automatic logic cell_legal(input logic [3:0] code);
    return (code >= CELL_A1) && (code <= CELL_C3);
  endfunction

  // Content of the cell named by code; illegal codes read as empty
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] code);
    logic [1:0] c;
    c = CELL_EMPTY;
    for (int k = 1; k <= 9; k++) begin
      if (code == k[3:0]) c = b[2*k-2 +: 2];
    end
    return c;
  endfunction

  function automatic logic [1:0] player_code(input logic who);
    return who ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/board_state_line_checker.sv
// Purpose: flags a completed row, column or diagonal for each player.
// Latency: purely combinational.
// Backpressure: none.
module line_checker
  import board_state_pkg::*;
(
  input  logic [17:0] board,
  output logic        p1_line,
  output logic        p2_line
);

  localparam logic [3:0] LINES [8][3] = '{
    '{CELL_A1, CELL_A2, CELL_A3},
    '{CELL_B1, CELL_B2, CELL_B3},
    '{CELL_C1, CELL_C2, CELL_C3},
    '{CELL_A1, CELL_B1, CELL_C1},
    '{CELL_A2, CELL_B2, CELL_C2},
    '{CELL_A3, CELL_B3, CELL_C3},
    '{CELL_A1, CELL_B2, CELL_C3},
    '{CELL_A3, CELL_B2, CELL_C1}
  };

  // Scan all eight lines for three matching marks of either player
  always_comb begin
    p1_line = 1'b0;
    p2_line = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (cell_at(board, LINES[l][0]) == CELL_P1 &&
          cell_at(board, LINES[l][1]) == CELL_P1 &&
          cell_at(board, LINES[l][2]) == CELL_P1) p1_line = 1'b1;
      if (cell_at(board, LINES[l][0]) == CELL_P2 &&
          cell_at(board, LINES[l][1]) == CELL_P2 &&
          cell_at(board, LINES[l][2]) == CELL_P2) p2_line = 1'b1;
    end
  end

endmodule

// File: rtl/board_state.sv
// Purpose: holds the 3x3 board, validates and commits moves, tracks turn order and game outcome.
// Latency: accept 3 cycles after the request edge, reject 2 (1 once the game is over); outcome 1 cycle after accept.
// Backpressure: busy high outside IDLE; requests while busy are dropped, never queued (OVER answers each with reject).
module board_state
  import board_state_pkg::*;
#(
  parameter bit ENFORCE_TURNS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  move,
  input  logic        move_valid,
  input  logic        user,
  output logic        busy,
  output logic        accept,
  output logic        reject,
  output logic [17:0] board,
  output logic [1:0]  outcome
);

  state_t     state, state_nxt;
  logic [3:0] move_q;
  logic       user_q;
  logic [3:0] count;
  logic       last_user;
  logic       p1_line, p2_line;
  logic [1:0] outcome_eval;
  logic       move_bad;

  line_checker u_line_checker (
    .board   (board),
    .p1_line (p1_line),
    .p2_line (p2_line)
  );

  // Outcome the current board implies; a line beats a full board so a 9th-move win is never a tie
  always_comb begin
    outcome_eval = OUTCOME_IN_PROGRESS;
    if (p1_line)                  outcome_eval = OUTCOME_WIN;
    else if (p2_line)             outcome_eval = OUTCOME_LOSE;
    else if (count == FULL_COUNT) outcome_eval = OUTCOME_TIE;
  end

  // Reasons to refuse the captured move: bad code, occupied cell, or same player twice
  always_comb begin
    move_bad = !cell_legal(move_q) ||
               (cell_at(board, move_q) != CELL_EMPTY) ||
               (ENFORCE_TURNS && (count != 4'd0) && (user_q == last_user));
  end

  // Next-state logic of the move pipeline
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (move_valid) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = move_bad ? ST_REJECT : ST_WRITE;
      ST_WRITE:  state_nxt = ST_EVAL;
      ST_EVAL:   state_nxt = (outcome_eval != OUTCOME_IN_PROGRESS) ? ST_OVER : ST_IDLE;
      ST_REJECT: state_nxt = ST_IDLE;
      ST_OVER:   state_nxt = ST_OVER;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status pulses, aligned with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      accept <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != ST_IDLE);
      accept <= (state_nxt == ST_EVAL);
      reject <= (state_nxt == ST_REJECT) || ((state == ST_OVER) && move_valid);
    end
  end

  // Request capture, board write, move bookkeeping and outcome update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_q    <= 4'd0;
      user_q    <= 1'b0;
      count     <= 4'd0;
      last_user <= 1'b0;
      board     <= '0;
      outcome   <= OUTCOME_IN_PROGRESS;
    end else begin
      if (state == ST_IDLE && move_valid) begin
        move_q <= move;
        user_q <= user;
      end
      if (state == ST_WRITE) begin
        for (int k = 1; k <= 9; k++) begin
          if (move_q == k[3:0]) board[2*k-2 +: 2] <= player_code(user_q);
        end
        count     <= (count == FULL_COUNT) ? count : count + 4'd1;
        last_user <= user_q;
      end
      if (state == ST_EVAL) outcome <= outcome_eval;
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Purpose: self-checking bench for board_state (directed table, corner sequences, random games vs reference model).
// Latency: n/a.
// Backpressure: n/a.
module tb_board_state;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  move = 4'd0;
  logic        move_valid = 1'b0;
  logic        user = 1'b0;
  logic        busy, accept, reject;
  logic [17:0] board;
  logic [1:0]  outcome;

  board_state #(.ENFORCE_TURNS(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .move       (move),
    .move_valid (move_valid),
    .user       (user),
    .busy       (busy),
    .accept     (accept),
    .reject     (reject),
    .board      (board),
    .outcome    (outcome)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: the game as a plain array of cells ----------------
  localparam int LN [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                               '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  int         cells [1:9];
  int         mcount;
  int         mlast;
  bit         mover;
  logic [1:0] mout;

  function automatic void model_reset();
    for (int k = 1; k <= 9; k++) cells[k] = 0;
    mcount = 0;
    mlast  = 0;
    mover  = 1'b0;
    mout   = 2'd0;
  endfunction

  // kind: 0 = refused because game over, 1 = refused, 2 = accepted
  task automatic model_step(input int m, input int u, output int kind);
    bit w1, w2;
    if (mover) kind = 0;
    else if (m < 1 || m > 9) kind = 1;
    else if (cells[m] != 0 || (mcount > 0 && u == mlast)) kind = 1;
    else begin
      kind = 2;
      cells[m] = u + 1;
      mcount++;
      mlast = u;
      w1 = 1'b0;
      w2 = 1'b0;
      for (int l = 0; l < 8; l++) begin
        if (cells[LN[l][0]] == 1 && cells[LN[l][1]] == 1 && cells[LN[l][2]] == 1) w1 = 1'b1;
        if (cells[LN[l][0]] == 2 && cells[LN[l][1]] == 2 && cells[LN[l][2]] == 2) w2 = 1'b1;
      end
      mout  = w1 ? 2'd1 : w2 ? 2'd2 : (mcount == 9) ? 2'd3 : 2'd0;
      mover = (mout != 2'd0);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int k = 1; k <= 9; k++) b[2*k-2 +: 2] = cells[k][1:0];
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    move_valid = 1'b0;
    #1;
    check({tag, " rst busy"},    busy,    0);
    check({tag, " rst accept"},  accept,  0);
    check({tag, " rst reject"},  reject,  0);
    check({tag, " rst board"},   board,   0);
    check({tag, " rst outcome"}, outcome, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One request, observed for five cycles; cycle 1 is the cycle after the sampling edge
  task automatic do_move(input logic [3:0] m, input logic u,
                         output int acc_cyc, output int rej_cyc,
                         output int n_acc, output int n_rej, output int both);
    acc_cyc = 0; rej_cyc = 0; n_acc = 0; n_rej = 0; both = 0;
    @(negedge clk);
    move = m;
    user = u;
    move_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) move_valid = 1'b0;
      if (accept) begin n_acc++; acc_cyc = i; end
      if (reject) begin n_rej++; rej_cyc = i; end
      if (accept && reject) both++;
    end
  endtask

  task automatic play(input string tag, input logic [3:0] m, input logic u, output bit got_acc);
    int kind, acc_cyc, rej_cyc, n_acc, n_rej, both;
    model_step(int'(m), int'(u), kind);
    do_move(m, u, acc_cyc, rej_cyc, n_acc, n_rej, both);
    check({tag, " accept_cycle"}, acc_cyc, (kind == 2) ? 3 : 0);
    check({tag, " reject_cycle"}, rej_cyc, (kind == 0) ? 1 : (kind == 1) ? 2 : 0);
    check({tag, " one_pulse"},    n_acc + n_rej, 1);
    check({tag, " no_overlap"},   both, 0);
    check({tag, " board"},        board, model_board());
    check({tag, " outcome"},      outcome, mout);
    check({tag, " busy"},         busy, mover);
    got_acc = (n_acc != 0);
  endtask

  typedef struct {
    bit         do_rst;
    logic [3:0] m;
    logic       u;
    bit         exp_acc;
    logic [1:0] exp_out;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input int m, input bit u, input bit a, input int o);
    vec_t v;
    v.do_rst = r; v.m = m[3:0]; v.u = u; v.exp_acc = a; v.exp_out = o[1:0];
    tbl.push_back(v);
  endfunction

  initial begin
    bit acc;
    int pulses, n_acc, n_rej;
    logic [3:0] rm;
    logic       ru;

    // center move, then occupied / illegal codes
    add(1,5,0,1,0); add(0,5,1,0,0); add(0,0,1,0,0); add(0,12,1,0,0);
    // same player twice
    add(1,1,0,1,0); add(0,2,0,0,0);
    // player 1 wins the top row; the game then refuses moves and holds outcome
    add(1,1,0,1,0); add(0,4,1,1,0); add(0,2,0,1,0); add(0,5,1,1,0); add(0,3,0,1,1); add(0,7,1,0,1);
    // full board, no line: tie
    add(1,1,0,1,0); add(0,2,1,1,0); add(0,3,0,1,0); add(0,5,1,1,0); add(0,4,0,1,0);
    add(0,6,1,1,0); add(0,8,0,1,0); add(0,7,1,1,0); add(0,9,0,1,3);
    // bottom-row win on the 9th move: win, not tie
    add(1,1,0,1,0); add(0,2,1,1,0); add(0,6,0,1,0); add(0,3,1,1,0); add(0,7,0,1,0);
    add(0,4,1,1,0); add(0,8,0,1,0); add(0,5,1,1,0); add(0,9,0,1,1);

    model_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) apply_reset("tbl");
      play("tbl", tbl[i].m, tbl[i].u, acc);
      check($sformatf("tbl%0d accepted", i), acc, tbl[i].exp_acc);
      check($sformatf("tbl%0d outcome_const", i), outcome, tbl[i].exp_out);
      if (i == 0) check("tbl0 cell5", board[9:8], 2'b01);
    end

    // requests while busy are ignored: valid held across CHECK and WRITE edges
    apply_reset("busy");
    model_step(5, 0, pulses);
    n_acc = 0; n_rej = 0;
    @(negedge clk);
    move = 4'd5; user = 1'b0; move_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin move = 4'd6; user = 1'b1; end
      if (i == 3) move_valid = 1'b0;
      if (accept) n_acc++;
      if (reject) n_rej++;
    end
    check("busy accepts", n_acc, 1);
    check("busy rejects", n_rej, 0);
    check("busy board",   board, model_board());

    // reset while the move is in WRITE aborts it cleanly
    apply_reset("r39");
    play("r39 first", 4'd1, 1'b0, acc);
    @(negedge clk);
    move = 4'd2; user = 1'b1; move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    check("r39 busy_in_write", busy, 1);
    rst = 1'b0;
    #1;
    check("r39 board",   board,   0);
    check("r39 busy",    busy,    0);
    check("r39 accept",  accept,  0);
    check("r39 outcome", outcome, 0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (accept || reject) pulses++;
    end
    check("r39 no_pulse", pulses, 0);
    rst = 1'b1;
    model_reset();
    play("r39 after", 4'd3, 1'b1, acc);
    check("r39 after accepted", acc, 1);

    // random games against the model
    apply_reset("rand");
    for (int g = 0; g < 300; g++) begin
      if ($urandom_range(0, 24) == 0 || (mover && $urandom_range(0, 2) == 0)) apply_reset("rand");
      if ($urandom_range(0, 4) == 0) rm = 4'($urandom_range(0, 15));
      else                           rm = 4'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0 || mcount == 0) ru = 1'($urandom_range(0, 1));
      else                                          ru = (mlast == 0);
      play("rand", rm, ru, acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 SHALL have parameter ENFORCE_TURNS, default 1; 1 = reject a move whose user equals the last accepted user.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port move  input  4  cell code; A1..C3 = 1..9, row-major; 0 and 10..15 are illegal.
REQ-005 SHALL have port move_valid  input  1  move request qualifier; sampled only in IDLE.
REQ-006 SHALL have port user  input  1  mover; 0 = player 1, 1 = player 2.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port accept  output  1  one-cycle pulse when a move is committed.
REQ-009 SHALL have port reject  output  1  one-cycle pulse when a move is refused.
REQ-010 SHALL have port board  output  18  2 bits per cell; cell k at bits [2k-1:2k-2]; 00 empty, 01 player 1, 10 player 2.
REQ-011 SHALL have port outcome  output  2  00 in_progress, 01 win (player 1), 10 lose (player 2 wins), 11 tie.

Function
REQ-012 SHALL implement states IDLE, CHECK, WRITE, EVAL, REJECT, OVER.
REQ-013 IDLE: move_valid=1 at edge T -> capture move/user, enter CHECK at T+1; move_valid=0 -> stay.
REQ-014 CHECK -> REJECT when any hold: move illegal; target cell non-empty; ENFORCE_TURNS=1, move count > 0, and user equals last accepted user.
REQ-015 CHECK -> WRITE otherwise.
REQ-016 REJECT: reject high for exactly this cycle (T+2), board unchanged, then IDLE.
REQ-017 WRITE (T+2): captured cell written with 01/10 per user; move count increments; last user recorded; then EVAL.
REQ-018 EVAL (T+3): accept high this cycle; evaluate 8 lines (3 rows, 3 columns, 2 diagonals); outcome updated, visible at T+4.
REQ-019 A complete line for player 1 SHALL give 01, for player 2 10; else full board (count = 9) gives 11; else 00.
REQ-020 A win on the 9th move SHALL report win/lose, never tie.
REQ-021 EVAL -> OVER if outcome becomes non-zero, else IDLE.
REQ-022 OVER: board and outcome frozen; each move_valid=1 gives a one-cycle reject pulse, one cycle later; leave OVER only by reset.
REQ-023 move_valid while busy SHALL be ignored; no queueing, no pulse.
REQ-024 First move of a game SHALL be accepted from either user.
REQ-025 accept and reject SHALL never be high in the same cycle; each move request yields exactly one of them.
REQ-026 All outputs SHALL be registered; no input-to-output combinational path.
REQ-027 Move counter SHALL be 4 bits, saturate at 9, never wrap.

Reset
REQ-028 rst low SHALL immediately force state IDLE, board all-zero, outcome 00, busy/accept/reject 0, move count 0, last user cleared.
REQ-029 Reset mid-operation (CHECK/WRITE/EVAL) SHALL abort the move with no accept/reject pulse and no board write.
REQ-030 First request is sampled on the first rising clk edge after rst deasserts.

Structure
REQ-031 Cell codes A1..C3, cell-content codes, outcome codes and state encodings SHALL live in the shared game constants package used by the turn FSM.
REQ-032 Line evaluation SHALL be one combinational sub-module, line_checker (board in; p1_line, p2_line out).
REQ-033 board_state SHALL be instantiated by the turn FSM, which supplies move/user and consumes outcome, accept, reject.

Verification
REQ-034 Reset, move=5 user=0 valid 1 cycle -> accept at T+3, board[9:8]=01, outcome 00.
REQ-035 After REQ-034, move=5 user=1 -> reject at T+2, board unchanged; move=0 or move=12 -> reject.
REQ-036 ENFORCE_TURNS=1: two consecutive user=0 moves 1 then 2 -> first accepted, second rejected.
REQ-037 Alternate moves p1:1,p2:4,p1:2,p2:5,p1:3 -> outcome 01 after last EVAL; next request rejected; outcome holds.
REQ-038 Sequence 1,2,3,5,4,6,8,7,9 (p1 first) -> outcome 11; sequence ending with a 9th-move row win -> 01, not 11.
REQ-039 rst low during WRITE -> board all-zero, no accept pulse, busy 0, next move accepted normally.
